// File: rtl/regfile_stream_ctrl.sv
// Load/drain initiator for a small register file: loads DEPTH words from an input stream,
// then reads them back onto a registered output stream in forward or reverse order.
module regfile_stream_ctrl #(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_reverse,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [N-1:0]  i_in_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [N-1:0]  o_out_data,
  output logic          o_rf_we,
  output logic [AW-1:0] o_rf_waddr,
  output logic [N-1:0]  o_rf_din,
  output logic [AW-1:0] o_rf_raddr,
  input  logic [N-1:0]  i_rf_dout,
  output logic          o_busy,
  output logic          o_done
);

  localparam int unsigned   CW     = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] LastC  = CW'(DEPTH - 1);
  localparam logic [AW-1:0] LastA  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e        r_state, w_state;
  logic [CW-1:0] r_wr_cnt, w_wr_cnt;
  logic [CW-1:0] r_rd_cnt, w_rd_cnt;
  logic          r_out_valid, w_out_valid;
  logic [N-1:0]  r_out_data, w_out_data;
  logic          r_rev, w_rev;
  logic          w_load;

  assign w_load      = (r_state == StLoad);
  assign o_in_ready  = w_load;
  assign o_rf_we     = w_load & i_in_valid;
  assign o_rf_waddr  = r_wr_cnt[AW-1:0];
  assign o_rf_din    = i_in_data;
  assign o_rf_raddr  = r_rev ? (LastA - r_rd_cnt[AW-1:0]) : r_rd_cnt[AW-1:0];
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = w_load | (r_state == StDrain);
  assign o_done      = (r_state == StDone);

  always_comb begin
    w_state     = r_state;
    w_wr_cnt    = r_wr_cnt;
    w_rd_cnt    = r_rd_cnt;
    w_out_valid = r_out_valid;
    w_out_data  = r_out_data;
    w_rev       = r_rev;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state  = StLoad;
          w_rev    = i_reverse;
          w_wr_cnt = '0;
        end
      end
      StLoad: begin
        if (i_in_valid) begin
          w_wr_cnt = r_wr_cnt + CW'(1);
          if (r_wr_cnt == LastC) begin
            w_state  = StDrain;
            w_rd_cnt = '0;
          end
        end
      end
      StDrain: begin
        // Refill the output register whenever it is empty or being consumed this cycle.
        if ((r_rd_cnt < DepthC) && (!r_out_valid || i_out_ready)) begin
          w_out_data  = i_rf_dout;
          w_out_valid = 1'b1;
          w_rd_cnt    = r_rd_cnt + CW'(1);
        end else if (i_out_ready) begin
          w_out_valid = 1'b0;
          if ((r_rd_cnt == DepthC) && r_out_valid) begin
            w_state = StDone;
          end
        end
      end
      StDone: w_state = StIdle;
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_rev       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_wr_cnt    <= w_wr_cnt;
      r_rd_cnt    <= w_rd_cnt;
      r_out_valid <= w_out_valid;
      r_out_data  <= w_out_data;
      r_rev       <= w_rev;
    end
  end

endmodule
